// File: rtl/mem_pkg.sv
// mem_pkg: shared optype codes, controller state encoding and field widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_pkg;

  localparam int PC_W  = 32;
  localparam int REG_W = 6;
  localparam int OP_W  = 4;

  localparam logic [OP_W-1:0] OP_LB = 4'd7;
  localparam logic [OP_W-1:0] OP_LW = 4'd8;
  localparam logic [OP_W-1:0] OP_SB = 4'd9;
  localparam logic [OP_W-1:0] OP_SW = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL       = 2'd1,
    ST_STORE_BUSY = 2'd2
  } state_t;

  // Shape a line word into the load result: LB is the low byte zero-extended.
  function automatic logic [31:0] fmt_load(input logic [OP_W-1:0] op, input logic [31:0] word);
    return (op == OP_LB) ? {24'b0, word[7:0]} : word;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped cache of one-word lines.
// Latency: combinational read by index; writes land on the next clock edge.
// Backpressure: none; the controller arbitrates the single write port.
module dcache_array
  import mem_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic [31-IDX_W:0] i_rd_tag,
  output logic              o_hit,
  output logic [31:0]       o_rd_data,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [31-IDX_W:0] i_wr_tag,
  input  logic [31:0]       i_wr_data,
  input  logic              i_wr_word,
  input  logic              i_wr_byte0,
  input  logic              i_wr_set_valid
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_idx];

  // Valid bits are the only state that reset must clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
    end else if (i_wr_set_valid) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload; a full-word write takes priority over a byte-0 write.
  always_ff @(posedge clk) begin
    if (i_wr_set_valid) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
    if (i_wr_word) begin
      r_data[i_wr_idx] <= i_wr_data;
    end else if (i_wr_byte0) begin
      r_data[i_wr_idx][7:0] <= i_wr_data[7:0];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through L1 data cache controller (no write-allocate); DCACHE_STATS_EN adds hit/miss/store counters.
// Latency: load hit answers the cycle after acceptance; a miss answers the cycle after mem_valid_in.
// Backpressure: req_ready is high only in IDLE; a fill or the STORE_LAT-cycle store window holds it low.
module dcache_ctrl
  import mem_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int STORE_LAT = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PC_W-1:0]  req_pc,
  input  logic [31:0]      req_addr,
  input  logic [REG_W-1:0] req_reg,
  input  logic [OP_W-1:0]  req_optype,
  input  logic [31:0]      req_data,
  output logic             resp_valid,
  output logic [PC_W-1:0]  resp_pc,
  output logic [REG_W-1:0] resp_reg,
  output logic [31:0]      resp_data,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             mem_miss,
  output logic [PC_W-1:0]  mem_pc,
  output logic [31:0]      mem_addr,
  output logic [REG_W-1:0] mem_reg,
  output logic [OP_W-1:0]  mem_optype,
  output logic [31:0]      mem_data,
  input  logic             mem_valid_in,
  input  logic [31:0]      mem_data_in
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses,
  output logic [31:0]      stat_stores
`endif
);
  localparam int TAG_W = 32 - IDX_W;
  localparam int CNT_W = $clog2(STORE_LAT + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [REG_W-1:0]   r_reg;
  logic [OP_W-1:0]    r_op;
  logic [31:0]        r_addr;

  logic               r_resp_valid, r_mem_rd, r_mem_wr, r_mem_miss;
  logic [PC_W-1:0]    r_resp_pc, r_mem_pc;
  logic [REG_W-1:0]   r_resp_reg, r_mem_reg;
  logic [31:0]        r_resp_data, r_mem_addr, r_mem_data;
  logic [OP_W-1:0]    r_mem_op;

  logic               w_hit, w_is_load, w_is_store;
  logic [31:0]        w_rd_data, w_wr_data;
  logic               w_ld_hit, w_ld_miss, w_st, w_fill;
  logic               w_wr_word, w_wr_byte0, w_wr_set_valid;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [TAG_W-1:0]   w_wr_tag;

  assign w_is_load  = (req_optype == OP_LB) || (req_optype == OP_LW);
  assign w_is_store = (req_optype == OP_SB) || (req_optype == OP_SW);
  assign req_ready  = (r_state == ST_IDLE);

  dcache_array #(.IDX_W(IDX_W)) u_array (
    .clk            (clk),
    .rstn           (rstn),
    .i_rd_idx       (req_addr[IDX_W-1:0]),
    .i_rd_tag       (req_addr[31:IDX_W]),
    .o_hit          (w_hit),
    .o_rd_data      (w_rd_data),
    .i_wr_idx       (w_wr_idx),
    .i_wr_tag       (w_wr_tag),
    .i_wr_data      (w_wr_data),
    .i_wr_word      (w_wr_word),
    .i_wr_byte0     (w_wr_byte0),
    .i_wr_set_valid (w_wr_set_valid)
  );

  // State and store-window counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, event decode and array write port; hit uses pre-write array contents.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ld_hit       = 1'b0;
    w_ld_miss      = 1'b0;
    w_st           = 1'b0;
    w_fill         = 1'b0;
    w_wr_word      = 1'b0;
    w_wr_byte0     = 1'b0;
    w_wr_set_valid = 1'b0;
    w_wr_idx       = req_addr[IDX_W-1:0];
    w_wr_tag       = req_addr[31:IDX_W];
    w_wr_data      = req_data;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_is_load) begin
            if (w_hit) begin
              w_ld_hit = 1'b1;
            end else begin
              w_ld_miss   = 1'b1;
              w_state_nxt = ST_FILL;
            end
          end else if (w_is_store) begin
            w_st        = 1'b1;
            w_wr_word   = w_hit && (req_optype == OP_SW);
            w_wr_byte0  = w_hit && (req_optype == OP_SB);
            w_cnt_nxt   = CNT_W'(STORE_LAT - 1);
            w_state_nxt = ST_STORE_BUSY;
          end
        end
      end
      ST_FILL: begin
        if (mem_valid_in) begin
          w_fill         = 1'b1;
          w_wr_set_valid = 1'b1;
          w_wr_word      = 1'b1;
          w_wr_idx       = r_addr[IDX_W-1:0];
          w_wr_tag       = r_addr[31:IDX_W];
          w_wr_data      = mem_data_in;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_STORE_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered response and memory-port outputs plus the miss context for the fill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_pc    <= '0;
      r_resp_reg   <= '0;
      r_resp_data  <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_miss   <= 1'b0;
      r_mem_pc     <= '0;
      r_mem_addr   <= '0;
      r_mem_reg    <= '0;
      r_mem_op     <= '0;
      r_mem_data   <= '0;
      r_pc         <= '0;
      r_reg        <= '0;
      r_op         <= '0;
      r_addr       <= '0;
    end else begin
      r_resp_valid <= w_ld_hit || w_fill;
      r_mem_rd     <= w_ld_miss;
      r_mem_wr     <= w_st;
      r_mem_miss   <= w_ld_miss || w_st;
      if (w_ld_hit) begin
        r_resp_pc   <= req_pc;
        r_resp_reg  <= req_reg;
        r_resp_data <= fmt_load(req_optype, w_rd_data);
      end else if (w_fill) begin
        r_resp_pc   <= r_pc;
        r_resp_reg  <= r_reg;
        r_resp_data <= fmt_load(r_op, mem_data_in);
      end
      if (w_ld_miss || w_st) begin
        r_mem_pc   <= req_pc;
        r_mem_addr <= req_addr;
        r_mem_reg  <= req_reg;
        r_mem_op   <= w_ld_miss ? OP_LW : req_optype;
        r_mem_data <= req_data;
      end
      if (w_ld_miss) begin
        r_pc   <= req_pc;
        r_reg  <= req_reg;
        r_op   <= req_optype;
        r_addr <= req_addr;
      end
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_pc      = r_resp_pc;
  assign resp_reg     = r_resp_reg;
  assign resp_data    = r_resp_data;
  assign mem_read_en  = r_mem_rd;
  assign mem_write_en = r_mem_wr;
  assign mem_miss     = r_mem_miss;
  assign mem_pc       = r_mem_pc;
  assign mem_addr     = r_mem_addr;
  assign mem_reg      = r_mem_reg;
  assign mem_optype   = r_mem_op;
  assign mem_data     = r_mem_data;

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hits, r_misses, r_stores;

  // Saturating event counters for accepted load hits, load misses and stores.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_stores <= '0;
    end else begin
      if (w_ld_hit && (r_hits != '1)) r_hits <= r_hits + 1'b1;
      if (w_ld_miss && (r_misses != '1)) r_misses <= r_misses + 1'b1;
      if (w_st && (r_stores != '1)) r_stores <= r_stores + 1'b1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
  assign stat_stores = r_stores;
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through L1 data cache controller. It sits directly upstream of the 10-cycle data memory and receives load/store requests from the LSU/issue stage. Load hits are answered in one cycle. On a load miss, a word fill is issued to data memory with the miss strobe asserted, the controller waits for the memory's valid return, then fills the line and answers. Only one memory operation is outstanding at a time, matching the memory's single port.

Parameters:
IDX_W, 4, index bits; the cache holds 2**IDX_W one-word lines.
STORE_LAT, 10, cycles the memory port stays busy after a store issue.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when high together with req_valid
req_pc  in  32  instruction PC tag
req_addr  in  32  word address
req_reg  in  6  destination physical register (loads)
req_optype  in  4  7=LB, 8=LW, 9=SB, 10=SW
req_data  in  32  store data
resp_valid  out  1  load result valid (1-cycle pulse)
resp_pc  out  32  PC of the completing load
resp_reg  out  6  destination register of the completing load
resp_data  out  32  load data (LB zero-extended)
mem_read_en  out  1  memory read strobe
mem_write_en  out  1  memory write strobe
mem_miss  out  1  cacheMiss strobe; high whenever mem_read_en or mem_write_en is high
mem_pc  out  32  PC forwarded to memory
mem_addr  out  32  address to memory
mem_reg  out  6  register tag to memory
mem_optype  out  4  always LW for fills; SB/SW for stores
mem_data  out  32  store data to memory
mem_valid_in  in  1  memory read data valid
mem_data_in  in  32  memory read data

Behaviour:
- Reset (rstn low, asynchronous): all line valid bits cleared; state=IDLE; every output 0 except req_ready=1.
- Line layout: valid bit, tag=addr[31:IDX_W], 32-bit data. index=addr[IDX_W-1:0].
- FSM states: IDLE, FILL, STORE_BUSY. req_ready=1 only in IDLE.
- IDLE, load hit: on the next edge assert resp_valid with line data. LW returns the full word; LB returns {24'b0, data[7:0]}. The FSM stays in IDLE, so back-to-back hits sustain 1 per cycle.
- IDLE, load miss: for one cycle drive mem_read_en=1, mem_miss=1, mem_optype=LW, mem_addr/mem_reg/mem_pc = the request's values. Latch pc/reg/optype/addr, then go to FILL.
- FILL: wait for mem_valid_in. On that cycle, write mem_data_in into the line (valid=1, tag updated) and, on the next edge, pulse resp_valid with the LB/LW-formatted data. Return to IDLE.
- IDLE, store (SB/SW): write-through, no write-allocate.
  - Hit, SW: the line word is replaced.
  - Hit, SB: only byte [7:0] of the line word is replaced.
  - Miss: the cache is unchanged.
  - Always: pulse mem_write_en=1, mem_miss=1 with optype/addr/data, then go to STORE_BUSY with a counter loaded to STORE_LAT-1.
- STORE_BUSY: decrement the counter each cycle; return to IDLE when it reaches 0. No response is produced for stores.
- Unknown optype in IDLE: accepted, dropped, no memory access, no response.
- mem_valid_in outside FILL: ignored.
- Reset during FILL or STORE_BUSY: aborts; the late memory return is ignored because state=IDLE.
- Hit/miss is evaluated against the array state before any same-cycle fill write. A fill and a request never coincide, since req_ready=0 in FILL.

Optional Feature:
DCACHE_STATS_EN: when defined, adds outputs stat_hits[31:0], stat_misses[31:0] and stat_stores[31:0].
- Counters increment on accepted load hits, load misses and stores respectively.
- Counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg: optype constants (LB=7, LW=8, SB=9, SW=10), the FSM state encoding, and the width constants for PC (32), register tag (6) and optype (4).
- Sub-module dcache_array holds valid/tag/data storage.
  - Combinational read by index; hit = valid & tag match.
  - Synchronous write port with byte-0 and full-word enables.
  - Asynchronous valid clear on rstn.

Test Plan:
- Cold LW addr 0x5 after memory preloaded 0xDEADBEEF -> mem_read_en pulse, resp_valid one cycle after mem_valid_in with resp_data 0xDEADBEEF; a repeat LW 0x5 hits with response next cycle and no mem_read_en.
- LB addr 0x5 after that fill -> hit, resp_data 0x000000EF.
- SW addr 0x5 data 0x12345678, then LW 0x5 -> mem_write_en pulse, req_ready low for exactly 10 cycles, then hit returns 0x12345678.
- SB addr 0x5 data 0xAA on the cached line -> LW 0x5 hit returns 0x123456AA; SB to an uncached address leaves that line invalid (the next load misses).
- Conflict: LW 0x5 then LW 0x15 (same index, IDX_W=4) -> second access misses and evicts; LW 0x5 misses again.
- Assert rstn low during FILL -> all outputs reset, req_ready=1; the stale mem_valid_in produces no resp_valid; LW 0x5 misses.
